lfsr_checker: RTL and testbench
===============================

// Module: lfsr_checker
// PURPOSE
//  Downstream checker for the 8-bit Galois LFSR generator (poly x^8+x^4+x^3+x^2+1).
//  Consumes the generated byte stream, self-synchronises to it, declares lock, and
//  counts mismatching bytes once locked. Used as the receive-side BER monitor.
// PARAMETERS
//  LOCK_CNT    4   consecutive matches in SEARCH needed to enter LOCKED (>=1)
//  UNLOCK_CNT  3   consecutive mismatches in LOCKED needed to return to SEARCH (>=1)
//  ERR_W       16  width of saturating error counter
// PORTS
//  clk          in   1      system clock, all logic on posedge
//  i_rst        in   1      synchronous reset, active-high
//  i_valid      in   1      i_data carries a new LFSR byte this cycle
//  i_data       in   8      received LFSR byte
//  i_clr_cnt    in   1      synchronous clear of o_err_cnt
//  o_lock       out  1      1 = checker locked to the sequence
//  o_err        out  1      one-cycle pulse: last accepted byte mismatched while LOCKED
//  o_err_cnt    out  ERR_W  saturating count of mismatches while LOCKED
// BEHAVIOUR
//  Next-state function f(c) (must equal generator step):
//   f(c) = {c[6], c[5], c[4], c[3]^c[7], c[2]^c[7], c[1]^c[7], c[0], c[7]}
//   e.g. f(8'h01)=8'h02, f(8'h80)=8'h1D.
//  Registers: state, ref_reg[7:0], have_ref, match_cnt, miss_cnt, o_err, o_err_cnt.
//  Reset (i_rst=1 at edge): state=SEARCH, ref_reg=0, have_ref=0, match_cnt=0,
//   miss_cnt=0, o_lock=0, o_err=0, o_err_cnt=0. Reset mid-operation discards lock.
//  No cycle without i_valid changes any register except o_err (cleared to 0) and
//   o_err_cnt (i_clr_cnt). Back-to-back i_valid every cycle must be supported.
//  expected = f(ref_reg); match = have_ref && (i_data == expected).
//  SEARCH (o_lock=0), on i_valid:
//   - ref_reg <= i_data; have_ref <= (i_data != 8'h00) (all-zero is lock-up, rejected).
//   - i_data==0 or !match: match_cnt <= 0.
//   - match: match_cnt+1; if it reaches LOCK_CNT -> LOCKED, match_cnt<=0, miss_cnt<=0.
//   - o_err stays 0, o_err_cnt not incremented in SEARCH.
//  LOCKED (o_lock=1), on i_valid:
//   - ref_reg <= expected (free-running local copy; one corrupted byte = one error).
//   - match: miss_cnt <= 0.
//   - mismatch: o_err <= 1 next cycle; o_err_cnt +1 saturating at 2^ERR_W-1;
//     miss_cnt+1; if it reaches UNLOCK_CNT -> SEARCH, have_ref<=0, match_cnt<=0,
//     miss_cnt<=0 (the byte causing unlock is counted as an error).
//  Latency: o_err, o_err_cnt and o_lock reflect a byte on the cycle after its i_valid edge.
//  i_clr_cnt with a counted error in the same cycle: o_err_cnt <= 1 (clear then count).
//  i_clr_cnt alone: o_err_cnt <= 0; does not affect state or lock.
//  Minimum lock time from reset: LOCK_CNT+1 valid bytes (first only seeds ref_reg).
// STRUCTURE
//  Shared include lfsr_defs.vh: LFSR_W=8, tap localparam 8'h1D, function
//   lfsr_galois_next(c) implementing f(), state encodings SEARCH=1'b0 / LOCKED=1'b1.
//   Generator and checker both use lfsr_galois_next so polynomials cannot diverge.
//  No sub-module: single always block for state/counters, f() via the shared function.
// TESTING
//  1 Reset, feed generator stream from seed 8'h01 (01,02,04,08,10,...) every cycle
//    -> o_lock=1 one cycle after 5th byte; o_err never pulses; o_err_cnt=0.
//  2 Locked, corrupt one byte (08 sent as 09) -> single o_err pulse, o_err_cnt=1,
//    lock kept, next correct bytes give no further errors.
//  3 Locked, send 3 consecutive wrong bytes (8'hAA) -> o_err_cnt=3, o_lock falls
//    after 3rd; resume correct stream -> relock after 5 valid bytes.
//  4 Stream of 8'h00 from reset -> o_lock stays 0, o_err_cnt stays 0 indefinitely.
//  5 ERR_W=4, locked, 20 isolated single-byte errors (UNLOCK_CNT not reached)
//    -> o_err_cnt saturates at 4'hF; i_clr_cnt coincident with error -> 1.
//  6 Gapped i_valid (1 in 3 cycles) and i_rst asserted while LOCKED
//    -> gaps change nothing; reset gives o_lock=0, o_err_cnt=0 next cycle.

Source files
------------

// File: rtl/lfsr_checker_pkg.sv
// Shared definitions for the 8-bit Galois LFSR (x^8+x^4+x^3+x^2+1).
// The generator and the checker both step through lfsr_galois_next so their polynomials always match.
package lfsr_checker_pkg;

  localparam int                LFSR_W    = 8;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'h1D;

  typedef enum logic {
    ST_SEARCH = 1'b0,
    ST_LOCKED = 1'b1
  } chk_state_e;

  // Galois step: shift left and fold the tap mask in when the MSB falls out.
  function automatic logic [LFSR_W-1:0] lfsr_galois_next(input logic [LFSR_W-1:0] c);
    return {c[LFSR_W-2:0], 1'b0} ^ (c[LFSR_W-1] ? LFSR_TAPS : '0);
  endfunction

endpackage

// File: rtl/lfsr_checker_if.sv
// Byte stream and status bundle between an LFSR byte source and the checker.
// The source drives the master side. The checker is connected to the slave side.
interface lfsr_checker_if
  import lfsr_checker_pkg::*;
#(
  parameter int ERR_W = 16
) ();

  logic              i_valid;
  logic [LFSR_W-1:0] i_data;
  logic              i_clr_cnt;
  logic              o_lock;
  logic              o_err;
  logic [ERR_W-1:0]  o_err_cnt;

  modport master (
    output i_valid, i_data, i_clr_cnt,
    input  o_lock, o_err, o_err_cnt
  );

  modport slave (
    input  i_valid, i_data, i_clr_cnt,
    output o_lock, o_err, o_err_cnt
  );

endinterface

// File: rtl/lfsr_checker.sv
// Receive-side BER monitor. It self-synchronises to a Galois LFSR byte stream and declares lock.
// While locked it counts mismatching bytes in a saturating counter.
module lfsr_checker
  import lfsr_checker_pkg::*;
#(
  parameter int LOCK_CNT   = 4,
  parameter int UNLOCK_CNT = 3,
  parameter int ERR_W      = 16
) (
  input  logic          clk,
  input  logic          i_rst,
  lfsr_checker_if.slave bus
);

  localparam int MATCH_W = (LOCK_CNT   > 1) ? $clog2(LOCK_CNT)   : 1;
  localparam int MISS_W  = (UNLOCK_CNT > 1) ? $clog2(UNLOCK_CNT) : 1;
  localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_CNT - 1);
  localparam logic [MISS_W-1:0]  MISS_LAST  = MISS_W'(UNLOCK_CNT - 1);

  chk_state_e        state_q, state_d;
  logic [LFSR_W-1:0] ref_q, ref_d;
  logic              have_ref_q, have_ref_d;
  logic [MATCH_W-1:0] match_cnt_q, match_cnt_d;
  logic [MISS_W-1:0] miss_cnt_q, miss_cnt_d;
  logic              err_q, err_d;
  logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;

  logic [LFSR_W-1:0] expected;
  logic              match;
  logic              count_err;
  logic [ERR_W-1:0]  cnt_base;

  always_comb begin
    state_d     = state_q;
    ref_d       = ref_q;
    have_ref_d  = have_ref_q;
    match_cnt_d = match_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    err_d       = 1'b0;
    count_err   = 1'b0;

    expected = lfsr_galois_next(ref_q);
    match    = have_ref_q && (bus.i_data == expected);

    if (bus.i_valid) begin
      unique case (state_q)
        ST_SEARCH: begin
          // Re-seed from every received byte. All-zero is the lock-up state and never seeds.
          ref_d      = bus.i_data;
          have_ref_d = (bus.i_data != '0);
          if (match) begin
            if (match_cnt_q == MATCH_LAST) begin
              state_d     = ST_LOCKED;
              match_cnt_d = '0;
              miss_cnt_d  = '0;
            end else begin
              match_cnt_d = match_cnt_q + 1'b1;
            end
          end else begin
            match_cnt_d = '0;
          end
        end
        ST_LOCKED: begin
          // Free-run the local copy so one corrupted byte costs exactly one error.
          ref_d = expected;
          if (match) begin
            miss_cnt_d = '0;
          end else begin
            err_d     = 1'b1;
            count_err = 1'b1;
            if (miss_cnt_q == MISS_LAST) begin
              state_d     = ST_SEARCH;
              have_ref_d  = 1'b0;
              match_cnt_d = '0;
              miss_cnt_d  = '0;
            end else begin
              miss_cnt_d = miss_cnt_q + 1'b1;
            end
          end
        end
        default: state_d = ST_SEARCH;
      endcase
    end

    // A clear takes effect first. An error seen in the same cycle is then counted on top of it.
    cnt_base  = bus.i_clr_cnt ? '0 : err_cnt_q;
    err_cnt_d = cnt_base;
    if (count_err && (cnt_base != {ERR_W{1'b1}})) begin
      err_cnt_d = cnt_base + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q     <= ST_SEARCH;
      ref_q       <= '0;
      have_ref_q  <= 1'b0;
      match_cnt_q <= '0;
      miss_cnt_q  <= '0;
      err_q       <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      ref_q       <= ref_d;
      have_ref_q  <= have_ref_d;
      match_cnt_q <= match_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      err_q       <= err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign bus.o_lock    = (state_q == ST_LOCKED);
  assign bus.o_err     = err_q;
  assign bus.o_err_cnt = err_cnt_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Scoreboard bench for lfsr_checker. It drives the same stream into a 16-bit and a 4-bit error-counter instance.
// A behavioural model supplies the expected lock, error-pulse and count values for each cycle.
module tb_lfsr_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lfsr_checker_if #(.ERR_W(16)) bus16 ();
  lfsr_checker_if #(.ERR_W(4))  bus4 ();

  lfsr_checker #(.LOCK_CNT(4), .UNLOCK_CNT(3), .ERR_W(16)) dut16 (
    .clk(clk), .i_rst(rst), .bus(bus16)
  );
  lfsr_checker #(.LOCK_CNT(4), .UNLOCK_CNT(3), .ERR_W(4)) dut4 (
    .clk(clk), .i_rst(rst), .bus(bus4)
  );

  typedef struct {
    int l16; int e16; int c16;
    int l4;  int e4;  int c4;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   n_txn  = 0;

  // Model state, index 0 = 16-bit counter instance, 1 = 4-bit instance
  int m_lock[2], m_ref[2], m_have[2], m_mc[2], m_miss[2], m_err[2], m_cnt[2];
  int g;

  // Generator step as polynomial arithmetic: multiply by x and reduce mod x^8+x^4+x^3+x^2+1.
  function automatic int nxt(input int c);
    int r;
    r = (c * 2) % 256;
    if (c >= 128) r = r ^ 29;
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s txn=%0d actual=%0d required=%0d", name, n_txn, act, req);
    end
  endtask

  task automatic model_step(input int k, input int maxc, input bit r, input bit v,
                            input int d, input bit clr);
    int  e;
    bit  mt;
    if (r) begin
      m_lock[k] = 0; m_ref[k] = 0; m_have[k] = 0; m_mc[k] = 0;
      m_miss[k] = 0; m_err[k] = 0; m_cnt[k] = 0;
      return;
    end
    m_err[k] = 0;
    if (clr) m_cnt[k] = 0;
    if (v) begin
      e  = nxt(m_ref[k]);
      mt = (m_have[k] != 0) && (d == e);
      if (m_lock[k] == 0) begin
        m_ref[k]  = d;
        m_have[k] = (d != 0);
        if (mt) begin
          m_mc[k]++;
          if (m_mc[k] == 4) begin
            m_lock[k] = 1; m_mc[k] = 0; m_miss[k] = 0;
          end
        end else begin
          m_mc[k] = 0;
        end
      end else begin
        m_ref[k] = e;
        if (mt) begin
          m_miss[k] = 0;
        end else begin
          m_err[k] = 1;
          if (m_cnt[k] < maxc) m_cnt[k]++;
          m_miss[k]++;
          if (m_miss[k] == 3) begin
            m_lock[k] = 0; m_have[k] = 0; m_mc[k] = 0; m_miss[k] = 0;
          end
        end
      end
    end
  endtask

  task automatic drive(input bit r, input bit v, input int d, input bit clr);
    exp_t x;
    @(negedge clk);
    rst             = r;
    bus16.i_valid   = v;  bus4.i_valid   = v;
    bus16.i_data    = 8'(d); bus4.i_data = 8'(d);
    bus16.i_clr_cnt = clr; bus4.i_clr_cnt = clr;
    model_step(0, 65535, r, v, d, clr);
    model_step(1, 15,    r, v, d, clr);
    x.l16 = m_lock[0]; x.e16 = m_err[0]; x.c16 = m_cnt[0];
    x.l4  = m_lock[1]; x.e4  = m_err[1]; x.c4  = m_cnt[1];
    exp_q.push_back(x);
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 0, 1'b0);
    g = 1;
  endtask

  task automatic send_good(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 1'b1, g, 1'b0);
      g = nxt(g);
    end
  endtask

  task automatic send_bad(input int d, input bit clr);
    drive(1'b0, 1'b1, d, clr);
    g = nxt(g);
  endtask

  // Monitor: outputs for the inputs driven at a negedge are checked just after the following posedge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_txn++;
        chk("lock16",   int'(bus16.o_lock),    e.l16);
        chk("err16",    int'(bus16.o_err),     e.e16);
        chk("errcnt16", int'(bus16.o_err_cnt), e.c16);
        chk("lock4",    int'(bus4.o_lock),     e.l4);
        chk("err4",     int'(bus4.o_err),      e.e4);
        chk("errcnt4",  int'(bus4.o_err_cnt),  e.c4);
        $display("txn %0d rst=%0b v=%0b d=%02h clr=%0b -> lock=%0b err=%0b cnt16=%0d cnt4=%0d",
                 n_txn, rst, bus16.i_valid, bus16.i_data, bus16.i_clr_cnt,
                 bus16.o_lock, bus16.o_err, bus16.o_err_cnt, bus4.o_err_cnt);
      end
    end
  end

  initial begin
    g = 1;
    bus16.i_valid = 0; bus16.i_data = 0; bus16.i_clr_cnt = 0;
    bus4.i_valid  = 0; bus4.i_data  = 0; bus4.i_clr_cnt  = 0;

    // Lock acquisition from seed 01, then hold
    do_reset();
    send_good(10);

    // Single corrupted byte
    send_bad(g ^ 1, 1'b0);
    send_good(6);

    // Three consecutive wrong bytes force unlock, then relock
    send_bad(8'hAA, 1'b0);
    send_bad(8'hAA, 1'b0);
    send_bad(8'hAA, 1'b0);
    send_good(8);

    // All-zero stream never locks
    do_reset();
    for (int i = 0; i < 10; i++) drive(1'b0, 1'b1, 0, 1'b0);

    // Isolated errors saturate the narrow counter. Then clear coincides with an error, then a clear alone.
    do_reset();
    send_good(6);
    for (int i = 0; i < 20; i++) begin
      send_bad(g ^ 8'h40, 1'b0);
      send_good(2);
    end
    send_bad(g ^ 8'h01, 1'b1);
    send_good(2);
    drive(1'b0, 1'b0, 8'h5A, 1'b1);
    send_good(2);

    // Gapped valid with junk data in the gaps, then reset while locked
    do_reset();
    for (int i = 0; i < 12; i++) begin
      send_good(1);
      drive(1'b0, 1'b0, int'($urandom_range(0, 255)), 1'b0);
      drive(1'b0, 1'b0, int'($urandom_range(0, 255)), 1'b0);
    end
    send_bad(g ^ 8'h80, 1'b0);
    drive(1'b1, 1'b1, g, 1'b0);
    g = 1;
    send_good(3);

    // Randomised traffic: rare errors, clears and resets
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      bit r, v, c;
      int d;
      r = ($urandom_range(0, 299) == 0);
      v = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 63) == 0);
      if (!v)                               d = int'($urandom_range(0, 255));
      else if ($urandom_range(0, 15) == 0)  d = int'($urandom_range(0, 255));
      else                                  d = g;
      drive(r, v, d, c);
      if (r)      g = 1;
      else if (v) g = nxt(g);
    end

    repeat (4) @(negedge clk);
    chk("drain", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
